// File: rtl/game_session_controller_if.sv
// Game session signal bundle.
// master: the game world / test harness (drives ticks, keys, collision, deposits).
// slave : game_session_controller (drives state, menu, hp, score, level, flags).
// Parameters must match those of the controller instance it connects to.
interface game_session_controller_if #(
  parameter int HP_W       = 2,
  parameter int SCORE_W    = 8,
  parameter int NUM_LEVELS = 4
);
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

  logic               game_en;
  logic               key_right;
  logic               key_left;
  logic               key_select;
  logic               key_back;
  logic               collision;
  logic               box_dropped;

  logic [2:0]         state;
  logic               menu_selection;
  logic [HP_W-1:0]    current_hp;
  logic [SCORE_W-1:0] score;
  logic [LVL_W-1:0]   level;
  logic               invulnerable;
  logic               play_en;
  logic               level_up;

  modport master (
    output game_en, key_right, key_left, key_select, key_back, collision, box_dropped,
    input  state, menu_selection, current_hp, score, level, invulnerable, play_en, level_up
  );

  modport slave (
    input  game_en, key_right, key_left, key_select, key_back, collision, box_dropped,
    output state, menu_selection, current_hp, score, level, invulnerable, play_en, level_up
  );
endinterface

// File: rtl/game_session_controller.sv
// Game session controller: menu/instructions/play/pause/game-over flow,
// lives with post-hit invulnerability, score and level progression.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - game_session_controller_if.slave
//          in : game_en, key_right/left/select/back (raw, active-low),
//               collision, box_dropped
//          out: state, menu_selection, current_hp, score, level,
//               invulnerable, play_en (combinational), level_up
module game_session_controller #(
  parameter int MAX_LIVES       = 3,
  parameter int HP_W            = 2,
  parameter int SCORE_W         = 8,
  parameter int BOXES_PER_LEVEL = 5,
  parameter int NUM_LEVELS      = 4,
  parameter int INVULN_TICKS    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  game_session_controller_if.slave   bus
);
  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int PROG_W = (BOXES_PER_LEVEL > 1) ? $clog2(BOXES_PER_LEVEL) : 1;
  localparam int INV_W  = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    ST_START        = 3'd0,
    ST_PLAYING      = 3'd1,
    ST_INSTRUCTIONS = 3'd2,
    ST_GAME_OVER    = 3'd3,
    ST_PAUSED       = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Key synchronizers; bit order {back, select, left, right}.
  // prev_q holds the previous synchronized level so a press is a clean
  // one-cycle pulse on the registered high-to-low transition.
  logic [3:0] sync1_q, sync2_q, prev_q, press;
  logic       press_right, press_left, press_select, press_back;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {bus.key_back, bus.key_select, bus.key_left, bus.key_right};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    press        = prev_q & ~sync2_q;
    press_right  = press[0];
    press_left   = press[1];
    press_select = press[2];
    press_back   = press[3];
  end

  logic               menu_q;
  logic [HP_W-1:0]    hp_q;
  logic [SCORE_W-1:0] score_q;
  logic [LVL_W-1:0]   level_q;
  logic [PROG_W-1:0]  progress_q;
  logic [INV_W-1:0]   invuln_q;
  logic               level_up_q;

  logic playing, hit, fatal, start_game, deposit, prog_full, level_max;

  always_comb begin
    playing    = (state_q == ST_PLAYING);
    hit        = playing && bus.collision && (invuln_q == '0);
    fatal      = hit && (hp_q <= HP_W'(1));
    start_game = (state_q == ST_START) && press_select && !menu_q;
    deposit    = playing && bus.box_dropped;
    prog_full  = (progress_q == PROG_W'(BOXES_PER_LEVEL - 1));
    level_max  = (level_q == LVL_W'(NUM_LEVELS - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_START;
    else      state_q <= state_d;
  end

  // Next-state logic; a fatal hit outranks a simultaneous back press.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_START: begin
        if (press_select) state_d = menu_q ? ST_INSTRUCTIONS : ST_PLAYING;
      end
      ST_INSTRUCTIONS: begin
        if (press_back) state_d = ST_START;
      end
      ST_PLAYING: begin
        if (fatal)           state_d = ST_GAME_OVER;
        else if (press_back) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (press_select || press_back) state_d = ST_PLAYING;
      end
      ST_GAME_OVER: begin
        if (press_select) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  // Session datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      menu_q     <= 1'b0;
      hp_q       <= HP_W'(MAX_LIVES);
      score_q    <= '0;
      level_q    <= '0;
      progress_q <= '0;
      invuln_q   <= '0;
      level_up_q <= 1'b0;
    end else begin
      level_up_q <= 1'b0;

      if (start_game) begin
        hp_q       <= HP_W'(MAX_LIVES);
        score_q    <= '0;
        level_q    <= '0;
        progress_q <= '0;
        invuln_q   <= '0;
      end

      if ((state_q == ST_START) && !press_select && (press_left || press_right))
        menu_q <= ~menu_q;

      if ((state_q == ST_GAME_OVER) && press_select)
        menu_q <= 1'b0;

      if (playing) begin
        if (hit) begin
          if (hp_q != '0) hp_q <= hp_q - HP_W'(1);
          invuln_q <= INV_W'(INVULN_TICKS);
        end else if (bus.game_en && (invuln_q != '0)) begin
          invuln_q <= invuln_q - INV_W'(1);
        end

        // Deposits still count on the cycle a fatal hit ends the game.
        if (deposit) begin
          if (score_q != '1) score_q <= score_q + SCORE_W'(1);
          if (prog_full) begin
            progress_q <= '0;
            if (!level_max) begin
              level_q    <= level_q + LVL_W'(1);
              level_up_q <= 1'b1;
            end
          end else begin
            progress_q <= progress_q + PROG_W'(1);
          end
        end
      end
    end
  end

  // Output logic
  always_comb begin
    bus.state          = state_q;
    bus.menu_selection = menu_q;
    bus.current_hp     = hp_q;
    bus.score          = score_q;
    bus.level          = level_q;
    bus.invulnerable   = (invuln_q != '0);
    bus.level_up       = level_up_q;
    bus.play_en        = bus.game_en && (state_q == ST_PLAYING);
  end
endmodule

// File: tb/tb_game_session_controller.sv
// Self-checking bench for game_session_controller: directed scenarios
// followed by random play, all checked every cycle against a rule-level model.
module tb_game_session_controller;
  localparam int MAX_LIVES = 3;
  localparam int HP_W      = 2;
  localparam int SCORE_W   = 8;
  localparam int BPL       = 5;
  localparam int NL        = 4;
  localparam int INV       = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_session_controller_if #(.HP_W(HP_W), .SCORE_W(SCORE_W), .NUM_LEVELS(NL)) bus ();

  game_session_controller #(
    .MAX_LIVES(MAX_LIVES), .HP_W(HP_W), .SCORE_W(SCORE_W),
    .BOXES_PER_LEVEL(BPL), .NUM_LEVELS(NL), .INVULN_TICKS(INV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: state numbering as seen on the state output.
  int m_state, m_menu, m_hp, m_score, m_level, m_prog, m_grace, m_lvlup;
  // Raw key samples from the last three clock edges, newest in bit 0.
  // Order: 0 right, 1 left, 2 select, 3 back.
  bit [2:0] hist [4];
  bit kr = 1'b1, kl = 1'b1, ks = 1'b1, kb = 1'b1;
  int lvlup_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_menu = 0; m_hp = MAX_LIVES; m_score = 0;
    m_level = 0; m_prog = 0; m_grace = 0; m_lvlup = 0;
    for (int i = 0; i < 4; i++) hist[i] = 3'b111;
  endfunction

  // A key event fires at the edge that sees high two samples back and low
  // one sample back (two-stage synchronizer latency).
  function automatic void model_edge(input bit ge, input bit col, input bit box,
                                     input bit [3:0] raw);
    bit [3:0] ev;
    int ns;
    bit hit;
    for (int i = 0; i < 4; i++) begin
      ev[i]   = hist[i][2] & ~hist[i][1];
      hist[i] = {hist[i][1:0], raw[i]};
    end
    ns      = m_state;
    hit     = (m_state == 1) && col && (m_grace == 0);
    m_lvlup = 0;
    case (m_state)
      0: begin
        if (ev[2]) begin
          if (m_menu == 0) begin
            ns = 1; m_hp = MAX_LIVES; m_score = 0; m_level = 0; m_prog = 0; m_grace = 0;
          end else ns = 2;
        end else if (ev[0] || ev[1]) m_menu = 1 - m_menu;
      end
      2: if (ev[3]) ns = 0;
      1: begin
        if (hit) begin
          if (m_hp > 0) m_hp--;
          m_grace = INV;
        end else if (ge && m_grace > 0) m_grace--;
        if (box) begin
          if (m_score < (2 ** SCORE_W) - 1) m_score++;
          m_prog++;
          if (m_prog == BPL) begin
            m_prog = 0;
            if (m_level < NL - 1) begin m_level++; m_lvlup = 1; end
          end
        end
        if (hit && m_hp == 0) ns = 3;
        else if (ev[3])       ns = 4;
      end
      4: if (ev[2] || ev[3]) ns = 1;
      3: if (ev[2]) begin ns = 0; m_menu = 0; end
      default: ns = 0;
    endcase
    m_state = ns;
  endfunction

  task automatic check_all(input bit ge);
    chk("state",        32'(bus.state),          m_state);
    chk("menu",         32'(bus.menu_selection), m_menu);
    chk("hp",           32'(bus.current_hp),     m_hp);
    chk("score",        32'(bus.score),          m_score);
    chk("level",        32'(bus.level),          m_level);
    chk("invulnerable", 32'(bus.invulnerable),   (m_grace != 0) ? 1 : 0);
    chk("play_en",      32'(bus.play_en),        (ge && m_state == 1) ? 1 : 0);
    chk("level_up",     32'(bus.level_up),       m_lvlup);
  endtask

  task automatic cyc(input bit ge, input bit col, input bit box);
    bus.game_en     = ge;
    bus.key_right   = kr;
    bus.key_left    = kl;
    bus.key_select  = ks;
    bus.key_back    = kb;
    bus.collision   = col;
    bus.box_dropped = box;
    @(posedge clk);
    model_edge(ge, col, box, {kb, ks, kl, kr});
    #1;
    check_all(ge);
    if (bus.level_up === 1'b1) lvlup_seen++;
  endtask

  task automatic set_key(input int which, input bit v);
    case (which)
      0: kr = v;
      1: kl = v;
      2: ks = v;
      default: kb = v;
    endcase
  endtask

  task automatic press(input int which);
    set_key(which, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    set_key(which, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    bus.game_en = 1'b0; bus.collision = 1'b0; bus.box_dropped = 1'b0;
    bus.key_right = 1'b1; bus.key_left = 1'b1; bus.key_select = 1'b1; bus.key_back = 1'b1;
    #12;
    model_reset();
    check_all(1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Menu: right -> Instructions, select -> INSTRUCTIONS, back -> START
    press(0);
    chk("menu_after_right", 32'(bus.menu_selection), 1);
    press(2);
    chk("instr_state", 32'(bus.state), 2);
    press(1);
    chk("instr_ignores_left", 32'(bus.state), 2);
    press(3);
    chk("back_to_start", 32'(bus.state), 0);
    chk("menu_kept", 32'(bus.menu_selection), 1);
    press(1);

    // Start game
    press(2);
    chk("play_state", 32'(bus.state), 1);
    chk("play_hp", 32'(bus.current_hp), 3);
    chk("play_score", 32'(bus.score), 0);

    // Deposits and level progression with saturation at top level
    lvlup_seen = 0;
    repeat (20) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("dep_score", 32'(bus.score), 20);
    chk("dep_level", 32'(bus.level), 3);
    chk("dep_pulses", lvlup_seen, 3);

    // Pause: collisions/deposits ignored, play_en low, resume on select
    press(3);
    chk("paused_state", 32'(bus.state), 4);
    repeat (6) cyc(1'b1, 1'b1, 1'b1);
    chk("paused_play_en", 32'(bus.play_en), 0);
    chk("paused_hp", 32'(bus.current_hp), 3);
    press(2);
    chk("resume_state", 32'(bus.state), 1);

    // Held collision over 30 ticks costs all three lives
    for (int t = 0; t < 30; t++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("held_col_state", 32'(bus.state), 3);
    chk("held_col_hp", 32'(bus.current_hp), 0);
    press(2);
    chk("over_to_start", 32'(bus.state), 0);
    chk("over_menu", 32'(bus.menu_selection), 0);
    chk("over_score_held", 32'(bus.score), 20);

    // Fatal hit with simultaneous deposit
    press(2);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(INV);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(INV);
    chk("pre_fatal_hp", 32'(bus.current_hp), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("fatal_dep_state", 32'(bus.state), 3);
    chk("fatal_dep_score", 32'(bus.score), 1);
    press(2);

    // Hit coinciding with back press: non-fatal pauses, fatal ends game
    press(2);
    kb = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("hit_back_state", 32'(bus.state), 4);
    chk("hit_back_hp", 32'(bus.current_hp), 2);
    kb = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    press(2);
    ticks(INV);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(INV);
    kb = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("fatal_back_state", 32'(bus.state), 3);
    kb = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    press(2);

    // Asynchronous reset mid-game
    press(2);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(bus.game_en);
    chk("async_rst_state", 32'(bus.state), 0);
    #2;
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) kr = ~kr;
      if ($urandom_range(0, 9) == 0) kl = ~kl;
      if ($urandom_range(0, 9) == 0) ks = ~ks;
      if ($urandom_range(0, 11) == 0) kb = ~kb;
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
